// File: rtl/dispatch_unit.sv
// Dispatch front end: one-entry stage register, register scoreboard with writeback
// bypass, and tagged operand fields driven straight into the issue queue enqueue port.
module dispatch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int NREGS      = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  instr_valid_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  output logic                  instr_ready_o,
  input  logic                  full_i,
  output logic                  enq_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [ID_WIDTH-1:0]   id_o,
  output logic [32:0]           rs1_o,
  output logic [32:0]           rs2_o,
  output logic [32:0]           rd_o,
  input  logic                  wb_valid_i,
  input  logic [4:0]            wb_rd_i,
  input  logic [ID_WIDTH-1:0]   wb_id_i
);

  localparam int PADW = 32 - 5 - ID_WIDTH;
  localparam logic [ID_WIDTH:0] MAX_OUT = {1'b1, {ID_WIDTH{1'b0}}};

  logic                  s1_v_reg;
  logic [DATA_WIDTH-1:0] s1_ins_reg;
  logic [NREGS-1:0]      busy_reg;
  logic [ID_WIDTH-1:0]   tag_reg [NREGS];
  logic [ID_WIDTH-1:0]   next_id_reg;
  logic [ID_WIDTH:0]     outstanding_reg;

  logic       fire;
  logic [6:0] opcode;
  logic [4:0] rd_idx;
  logic       use_rs1, use_rs2, use_rd;
  logic       rd_wr;
  logic       wb_clr;
  logic       wb_dec;
  logic [NREGS-1:0] sb_set;
  logic [NREGS-1:0] sb_clr;

  logic [4:0]  src_idx   [2];
  logic        src_use   [2];
  logic [32:0] src_field [2];

  assign fire          = s1_v_reg && !full_i && (outstanding_reg != MAX_OUT);
  assign instr_ready_o = !s1_v_reg || fire;

  assign opcode     = s1_ins_reg[6:0];
  assign rd_idx     = s1_ins_reg[11:7];
  assign src_idx[0] = s1_ins_reg[19:15];
  assign src_idx[1] = s1_ins_reg[24:20];
  assign src_use[0] = use_rs1;
  assign src_use[1] = use_rs2;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      7'b0110111, 7'b0010111, 7'b1101111: use_rd = 1'b1;
      7'b1100111, 7'b0000011, 7'b0010011: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      7'b1100011, 7'b0100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0110011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      default: ;
    endcase
  end

  assign rd_wr = use_rd && (rd_idx != 5'd0);

  // A source is ready early when this cycle's writeback retires its producer tag.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic wb_hit;
      logic pend;
      assign wb_hit = wb_valid_i && (wb_rd_i == src_idx[gi]) &&
                      (tag_reg[src_idx[gi]] == wb_id_i);
      assign pend   = src_use[gi] && (src_idx[gi] != 5'd0) &&
                      busy_reg[src_idx[gi]] && !wb_hit;
      assign src_field[gi] = (fire && src_use[gi]) ?
                             {pend, {PADW{1'b0}}, tag_reg[src_idx[gi]], src_idx[gi]} : 33'd0;
    end
  endgenerate

  assign rs1_o  = src_field[0];
  assign rs2_o  = src_field[1];
  assign rd_o   = (fire && use_rd) ? {rd_wr, {PADW{1'b0}}, next_id_reg, rd_idx} : 33'd0;
  assign enq_o  = fire;
  assign data_o = fire ? s1_ins_reg : '0;
  assign id_o   = fire ? next_id_reg : '0;

  // Only the youngest producer of a register may clear it; stale tags are ignored.
  assign wb_clr = wb_valid_i && (wb_rd_i != 5'd0) && busy_reg[wb_rd_i] &&
                  (tag_reg[wb_rd_i] == wb_id_i);

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_sb
      assign sb_set[gi] = fire && rd_wr && (rd_idx == 5'(gi));
      assign sb_clr[gi] = wb_clr && (wb_rd_i == 5'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_reg <= '0;
      for (int i = 0; i < NREGS; i++) tag_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (sb_set[i]) begin
          busy_reg[i] <= 1'b1;
          tag_reg[i]  <= next_id_reg;
        end else if (sb_clr[i]) begin
          busy_reg[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_v_reg   <= 1'b0;
      s1_ins_reg <= '0;
    end else if (instr_valid_i && instr_ready_o) begin
      s1_v_reg   <= 1'b1;
      s1_ins_reg <= instr_i;
    end else if (fire) begin
      s1_v_reg <= 1'b0;
    end
  end

  assign wb_dec = wb_valid_i && (outstanding_reg != '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      next_id_reg     <= '0;
      outstanding_reg <= '0;
    end else begin
      if (fire) next_id_reg <= next_id_reg + 1'b1;
      case ({fire, wb_dec})
        2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
        2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dispatch_unit.sv
// Bench for dispatch_unit: directed scenarios plus randomized traffic checked
// against a behavioural scoreboard model.
module tb_dispatch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        instr_valid_i;
  logic [31:0] instr_i;
  logic        instr_ready_o;
  logic        full_i;
  logic        enq_o;
  logic [31:0] data_o;
  logic [3:0]  id_o;
  logic [32:0] rs1_o, rs2_o, rd_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic [3:0]  wb_id_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dispatch_unit #(.DATA_WIDTH(32), .ID_WIDTH(4), .NREGS(32)) dut (
    .clk(clk), .resetn(resetn),
    .instr_valid_i(instr_valid_i), .instr_i(instr_i), .instr_ready_o(instr_ready_o),
    .full_i(full_i), .enq_o(enq_o), .data_o(data_o), .id_o(id_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_id_i(wb_id_i)
  );

  // Behavioural model state
  bit          m_s1_v;
  logic [31:0] m_s1_ins;
  bit          m_busy [32];
  logic [3:0]  m_tag  [32];
  logic [3:0]  m_next_id;
  int          m_out;
  logic [8:0]  inflight [$];  // {id, rd written or 0}

  function automatic void decode(input logic [6:0] op, output bit u1, output bit u2, output bit ud);
    u1 = 0; u2 = 0; ud = 0;
    case (op)
      7'h37, 7'h17, 7'h6F: ud = 1;
      7'h67, 7'h03, 7'h13: begin u1 = 1; ud = 1; end
      7'h63, 7'h23:        begin u1 = 1; u2 = 1; end
      7'h33:               begin u1 = 1; u2 = 1; ud = 1; end
      default: ;
    endcase
  endfunction

  always @(posedge clk) begin
    bit f, dec, u1, u2, ud, wr, rdy;
    logic [4:0] rd;
    if (!resetn) begin
      m_s1_v = 0;
      m_s1_ins = '0;
      for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = '0; end
      m_next_id = '0;
      m_out = 0;
      inflight.delete();
    end else begin
      f = m_s1_v && !full_i && (m_out < 16);
      dec = wb_valid_i && (m_out > 0);
      decode(m_s1_ins[6:0], u1, u2, ud);
      rd = m_s1_ins[11:7];
      wr = ud && (rd != 0);
      if (wb_valid_i && wb_rd_i != 0 && m_busy[wb_rd_i] && m_tag[wb_rd_i] == wb_id_i)
        m_busy[wb_rd_i] = 0;
      if (f && wr) begin m_busy[rd] = 1; m_tag[rd] = m_next_id; end
      if (f) begin
        inflight.push_back({m_next_id, wr ? rd : 5'd0});
        m_next_id = m_next_id + 4'd1;
        m_out++;
      end
      if (dec) m_out--;
      rdy = !m_s1_v || f;
      if (instr_valid_i && rdy) begin m_s1_v = 1; m_s1_ins = instr_i; end
      else if (f) m_s1_v = 0;
    end
  end

  function automatic logic [32:0] exp_src(input bit used, input logic [4:0] idx);
    bit pend;
    pend = used && idx != 0 && m_busy[idx] &&
           !(wb_valid_i && wb_rd_i == idx && m_tag[idx] == wb_id_i);
    return used ? {pend, 23'd0, m_tag[idx], idx} : 33'd0;
  endfunction

  function automatic void predict(output bit e_ready, output bit e_enq, output logic [31:0] e_data,
                                  output logic [3:0] e_id, output logic [32:0] e_rs1,
                                  output logic [32:0] e_rs2, output logic [32:0] e_rd);
    bit u1, u2, ud;
    e_enq = m_s1_v && !full_i && (m_out < 16);
    e_ready = !m_s1_v || e_enq;
    e_data = '0; e_id = '0; e_rs1 = '0; e_rs2 = '0; e_rd = '0;
    if (e_enq) begin
      decode(m_s1_ins[6:0], u1, u2, ud);
      e_data = m_s1_ins;
      e_id = m_next_id;
      e_rs1 = exp_src(u1, m_s1_ins[19:15]);
      e_rs2 = exp_src(u2, m_s1_ins[24:20]);
      e_rd = ud ? {m_s1_ins[11:7] != 0, 23'd0, m_next_id, m_s1_ins[11:7]} : 33'd0;
    end
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic f,
                       input logic wv, input logic [4:0] wr, input logic [3:0] wid);
    instr_valid_i = v; instr_i = ins; full_i = f;
    wb_valid_i = wv; wb_rd_i = wr; wb_id_i = wid;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    resetn = 1'b1;
  endtask

  localparam logic [31:0] ADD3  = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] ADD5  = 32'h003182B3;  // add x5,x3,x3
  localparam logic [31:0] ADDI7 = 32'h00100393;  // addi x7,x0,1
  localparam logic [31:0] PRB7  = 32'h00038413;  // addi x8,x7,0
  localparam logic [31:0] PRB3  = 32'h00018213;  // addi x4,x3,0

  task automatic test_reset();
    drive(1, 32'hDEADBEEF, 0, 0, 0, 0);
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (instr_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", instr_ready_o);
    end
    checks++;
    if ({enq_o, data_o, id_o, rs1_o, rs2_o, rd_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: enq=%b data=%h id=%h rs1=%h rs2=%h rd=%h expected all 0",
                         enq_o, data_o, id_o, rs1_o, rs2_o, rd_o);
    end
  endtask

  task automatic test_add();
    do_reset();
    drive(1, ADD3, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({enq_o, id_o, data_o} !== {1'b1, 4'd0, ADD3}) begin
      errors++; $display("FAIL add_enq: enq=%b id=%h data=%h expected 1/0/%h", enq_o, id_o, data_o, ADD3);
    end
    checks++;
    if ({rs1_o, rs2_o, rd_o} !== {33'h1, 33'h2, 33'h1_0000_0003}) begin
      errors++; $display("FAIL add_fields: rs1=%h rs2=%h rd=%h expected 1/2/100000003", rs1_o, rs2_o, rd_o);
    end
    $display("txn add: id=%0d rs1=%h rs2=%h rd=%h", id_o, rs1_o, rs2_o, rd_o);
    tick();
    drive(1, PRB3, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({rs1_o, id_o} !== {33'h1_0000_0003, 4'd1}) begin
      errors++; $display("FAIL add_busy3: rs1=%h id=%h expected 100000003/1", rs1_o, id_o);
    end
    tick();
  endtask

  task automatic test_back_to_back(input bit bypass);
    logic [32:0] exp_s;
    do_reset();
    drive(1, ADD3, 0, 0, 0, 0);
    tick();
    drive(1, ADD5, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({enq_o, instr_ready_o, id_o} !== {1'b1, 1'b1, 4'd0}) begin
      errors++; $display("FAIL b2b_first: enq=%b ready=%b id=%h expected 1/1/0", enq_o, instr_ready_o, id_o);
    end
    tick();
    drive(0, 0, 0, bypass, bypass ? 5'd3 : 5'd0, 0);
    @(negedge clk);
    exp_s = {!bypass, 23'd0, 4'd0, 5'd3};
    checks++;
    if ({rs1_o, rs2_o} !== {exp_s, exp_s}) begin
      errors++; $display("FAIL b2b_src(bypass=%0d): rs1=%h rs2=%h expected %h", bypass, rs1_o, rs2_o, exp_s);
    end
    checks++;
    if ({enq_o, id_o, rd_o} !== {1'b1, 4'd1, 33'h1_0000_0025}) begin
      errors++; $display("FAIL b2b_second: enq=%b id=%h rd=%h expected 1/1/100000025", enq_o, id_o, rd_o);
    end
    $display("txn b2b: bypass=%0d id=%0d rs1=%h rs2=%h", bypass, id_o, rs1_o, rs2_o);
    tick();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_full_stall();
    do_reset();
    drive(1, ADD3, 0, 0, 0, 0);
    tick();
    drive(1, ADD5, 1, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({enq_o, instr_ready_o} !== 2'b00) begin
        errors++; $display("FAIL stall_hold c%0d: enq=%b ready=%b expected 0/0", c, enq_o, instr_ready_o);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({enq_o, data_o, id_o} !== {1'b1, ADD3, 4'd0}) begin
      errors++; $display("FAIL stall_release: enq=%b data=%h id=%h expected 1/%h/0", enq_o, data_o, id_o, ADD3);
    end
    tick();
    @(negedge clk);
    checks++;
    if (enq_o !== 1'b0) begin
      errors++; $display("FAIL stall_noload: enq=%b expected 0", enq_o);
    end
    // reset in the middle of a stall drops the held instruction
    drive(1, ADD3, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0, 0);
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({enq_o, instr_ready_o} !== 2'b01) begin
      errors++; $display("FAIL stall_reset: enq=%b ready=%b expected 0/1", enq_o, instr_ready_o);
    end
  endtask

  task automatic test_stale_wb();
    do_reset();
    drive(1, ADDI7, 0, 0, 0, 0); tick();
    drive(1, ADDI7, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);     tick();
    drive(0, 0, 0, 1, 7, 0);     tick();
    drive(1, PRB7, 0, 0, 0, 0);  tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({rs1_o, id_o} !== {33'h1_0000_0027, 4'd2}) begin
      errors++; $display("FAIL stale_kept: rs1=%h id=%h expected 100000027/2", rs1_o, id_o);
    end
    tick();
    drive(0, 0, 0, 1, 7, 1);     tick();
    drive(1, PRB7, 0, 0, 0, 0);  tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({rs1_o, id_o} !== {33'h0_0000_0027, 4'd3}) begin
      errors++; $display("FAIL stale_cleared: rs1=%h id=%h expected 000000027/3", rs1_o, id_o);
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 32'h00000013, 0, 0, 0, 0);
      tick();
    end
    drive(1, 32'h00500013, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({enq_o, instr_ready_o} !== 2'b00) begin
      errors++; $display("FAIL wrap_hold: enq=%b ready=%b expected 0/0", enq_o, instr_ready_o);
    end
    tick();
    drive(0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({enq_o, id_o, data_o} !== {1'b1, 4'd0, 32'h00500013}) begin
      errors++; $display("FAIL wrap_release: enq=%b id=%h data=%h expected 1/0/00500013", enq_o, id_o, data_o);
    end
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    drive(1, 32'h00100013, 0, 0, 0, 0);
    tick();
    drive(1, 32'h000002B3, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({enq_o, rs1_o, rd_o} !== {1'b1, 33'd0, 33'd0}) begin
      errors++; $display("FAIL x0_fields: enq=%b rs1=%h rd=%h expected 1/0/0", enq_o, rs1_o, rd_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({rs1_o, rs2_o, id_o, rd_o} !== {33'd0, 33'd0, 4'd1, 33'h1_0000_0025}) begin
      errors++; $display("FAIL x0_nobusy: rs1=%h rs2=%h id=%h rd=%h expected 0/0/1/100000025",
                         rs1_o, rs2_o, id_o, rd_o);
    end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h63, 7'h23, 7'h33, 7'h7F};
    logic [31:0] ins;
    logic [8:0]  ent;
    int          k;
    bit          e_ready, e_enq;
    logic [31:0] e_data;
    logic [3:0]  e_id;
    logic [32:0] e_rs1, e_rs2, e_rd;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      drive($urandom_range(0, 9) < 7, ins, $urandom_range(0, 9) < 2, 0, 0, 0);
      if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, inflight.size() - 1);
        ent = inflight[k];
        inflight.delete(k);
        wb_valid_i = 1'b1;
        wb_rd_i = ent[4:0];
        wb_id_i = ent[8:5];
      end
      @(negedge clk);
      predict(e_ready, e_enq, e_data, e_id, e_rs1, e_rs2, e_rd);
      checks++;
      if ({instr_ready_o, enq_o} !== {e_ready, e_enq}) begin
        errors++; $display("FAIL rnd_hs c%0d: ready=%b enq=%b expected %b/%b", c, instr_ready_o, enq_o, e_ready, e_enq);
      end
      checks++;
      if ({data_o, id_o} !== {e_data, e_id}) begin
        errors++; $display("FAIL rnd_data c%0d: data=%h id=%h expected %h/%h", c, data_o, id_o, e_data, e_id);
      end
      checks++;
      if ({rs1_o, rs2_o, rd_o} !== {e_rs1, e_rs2, e_rd}) begin
        errors++; $display("FAIL rnd_fields c%0d: rs1=%h rs2=%h rd=%h expected %h/%h/%h",
                           c, rs1_o, rs2_o, rd_o, e_rs1, e_rs2, e_rd);
      end
      if (enq_o) $display("txn rnd c%0d: id=%0d data=%h rs1=%h rs2=%h rd=%h", c, id_o, data_o, rs1_o, rs2_o, rd_o);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_add();
    test_back_to_back(0);
    test_back_to_back(1);
    test_full_stall();
    test_stale_wb();
    test_wrap();
    test_x0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dispatch_unit.md
# dispatch_unit

Front end of the dynamic-issue path. It accepts decoded RV32I instructions from fetch/decode with a valid/ready handshake and holds one instruction in a stage register. It looks up a register scoreboard, then drives the issue queue's enqueue port with tagged 33-bit rs1/rs2/rd fields and a per-instruction ID. Writeback broadcasts from the execution units clear scoreboard entries and retire in-flight IDs.

## Interface
- DATA_WIDTH, 32, instruction width
- ID_WIDTH, 4, instruction ID / producer-tag width; at most 2^ID_WIDTH instructions in flight
- NREGS, 32, architectural registers (index width 5)

- clk  in  1  clock, all state on rising edge
- resetn  in  1  synchronous, active-low reset
- instr_valid_i  in  1  upstream instruction valid
- instr_i  in  DATA_WIDTH  instruction word
- instr_ready_o  out  1  stage register can accept
- full_i  in  1  issue queue full
- enq_o  out  1  enqueue strobe to issue queue
- data_o  out  DATA_WIDTH  instruction to queue
- id_o  out  ID_WIDTH  ID assigned to enqueued instruction
- rs1_o, rs2_o, rd_o  out  33 each  tagged operand fields
- wb_valid_i  in  1  completion broadcast
- wb_rd_i  in  5  written register (0 = no write)
- wb_id_i  in  ID_WIDTH  ID of completing instruction

## Operation
- Stage register S1 has valid bit s1_v and instruction s1_ins.
- Fire condition: fire = s1_v & !full_i & (outstanding != 2^ID_WIDTH).
- instr_ready_o = !s1_v | fire. On instr_valid_i & instr_ready_o, S1 loads instr_i and s1_v=1. Otherwise, on fire, s1_v=0.
- Field decode: rd=[11:7], rs1=[19:15], rs2=[24:20].
- Field use by opcode [6:0]:
  - 0110111, 0010111, 1101111: rd only.
  - 1100111, 0000011, 0010011: rs1, rd.
  - 1100011, 0100011: rs1, rs2.
  - 0110011: rs1, rs2, rd.
  - Any other opcode: no fields, but the instruction is still enqueued.
- Source field format: [4:0] register index; [4+ID_WIDTH:5] producer tag; remaining low bits 0; [32] pending.
  - pending=1 only when the field is used, index != 0, busy[index]=1, and there is no same-cycle matching writeback (see bypass).
  - Unused field: all 33 bits 0.
- rd_o format: [4:0] rd; [4+ID_WIDTH:5] id_o; [32]=1 when rd is used and rd != 0.
- Scoreboard: busy[NREGS] and tag[NREGS][ID_WIDTH].
  - On a writeback where wb_rd_i != 0, busy[wb_rd_i] & tag[wb_rd_i]==wb_id_i: clear busy.
  - On fire with rd_o[32]=1: busy[rd]=1 and tag[rd]=id_o.
  - If both target the same register in one cycle, the dispatch write wins.
- Bypass: if a source register is busy and the same-cycle writeback matches its tag, that source is ready (pending=0).
- ID counter next_id: increments mod 2^ID_WIDTH on each fire.
- outstanding counter (ID_WIDTH+1 bits): +1 on fire, −1 on wb_valid_i, net 0 when both occur.
  - Every instruction, including non-writers, produces exactly one wb_valid_i.
  - wb_valid_i with outstanding==0 is ignored.
- busy[0] is never set.

## Timing
- enq_o, data_o, id_o, rs*_o and rd_o are combinational from S1, the scoreboard and the wb_* inputs.
- enq_o = fire. data_o = s1_ins. id_o = next_id.
- Outputs are meaningful only when enq_o=1; otherwise the field outputs are driven 0.
- Latency: an instruction accepted at edge N is enqueued at the earliest at edge N+1, when it is in S1 and full_i is low.
- Throughput: one instruction per cycle, because S1 loads in the same cycle it fires.
- full_i high: S1 holds its contents, instr_ready_o=0 while S1 is valid, and no scoreboard or ID change occurs.
- Scoreboard updates become visible to the next cycle's lookup. A dependent back-to-back instruction sees busy=1 with the tag of its producer.
- Reset (resetn low at any edge, including mid-stall):
  - s1_v=0, busy all 0, tags 0, next_id=0, outstanding=0.
  - Outputs: instr_ready_o=1 in the first cycle after reset; enq_o=0; data_o, id_o and fields are 0.
  - An in-flight S1 instruction is dropped.

## Test plan
- Reset, then send ADD x3,x1,x2 (0x002081B3) with the queue not full. Required next cycle:
  - enq_o=1, id_o=0
  - rs1_o=33'h1, rs2_o=33'h2, both pending 0
  - rd_o=33'h1_0000_0003, busy[3]=1
- Back-to-back ADD x3,x1,x2 then ADD x5,x3,x3. Required on the second enqueue:
  - rs1_o and rs2_o have pending=1, index 3, tag 0, and id_o=1.
  - Also send wb x3/id 0 in the same cycle as the second enqueue: both sources have pending=0.
- Hold full_i=1 for 3 cycles with S1 loaded. Required:
  - enq_o=0 and instr_ready_o=0 throughout.
  - When full_i drops, the held instruction enqueues unchanged, and next_id has not advanced.
- Stale writeback: dispatch two writers of x7 (ids 0 and 1), then wb x7/id 0. Required: busy[7] stays 1. wb x7/id 1 clears it.
- Fire 16 instructions with no writebacks. Required:
  - 17th is held, instr_ready_o=0.
  - One wb_valid_i releases it with id_o=0, showing wrap-around.
- Send x0 operands, e.g. ADDI x0,x0,1 (0x00100013). Required: rs1 pending=0, rd_o[32]=0, and no busy bit is set.
